multicycle_ctrl: RTL
====================

# multicycle_ctrl

FSM control unit for the multi-cycle RV32I core, successor to the combinational single-cycle decoder. It sequences each instruction through fetch, decode, execute, memory and write-back. It handshakes with a shared instruction/data memory that may insert wait states, and it evaluates branch conditions from comparator flags. It also provides a memory-timeout fault and a retired-instruction counter.

## Interface
- MEM_TIMEOUT, default 15: maximum wait cycles on a memory request before fault; 0 disables the timeout.
- CNT_W, default 32: width of the retired-instruction counter.
- ALU_OP_W, default 4: ALU opcode width.
- i_clk  in  1  core clock.
- i_reset  in  1  synchronous, active-high reset.
- i_instr  in  32  instruction register contents, stable from DECODE until the instruction retires.
- i_mem_ack  in  1  memory completion; sampled only while o_mem_req=1.
- i_br_equal  in  1  comparator: rs1 == rs2.
- i_br_less  in  1  comparator: rs1 < rs2, signed or unsigned per o_br_unsign.
- o_mem_req  out  1  memory request.
- o_mem_wren  out  1  store qualifier on o_mem_req.
- o_mem_fetch  out  1  request is an instruction fetch; address = PC.
- o_ir_wren  out  1  load the instruction register.
- o_pc_wren  out  1  update the PC.
- o_pc_sel  out  1  next-PC select: 0 = PC+4, 1 = ALU result.
- o_br_unsign  out  1  unsigned compare.
- o_op1_sel  out  1  ALU A select: 0 = rs1, 1 = PC.
- o_op2_sel  out  1  ALU B select: 0 = rs2, 1 = imm.
- o_alu_opcode  out  ALU_OP_W  ALU operation.
- o_rd_wren  out  1  register-file write.
- o_wb_sel  out  2  write-back select: 00 = ALU, 10 = load data, 11 = PC+4.
- o_retire  out  1  one-cycle pulse when an instruction completes.
- o_instret  out  CNT_W  retired-instruction count.
- o_fault  out  1  sticky memory-timeout flag.
- o_illegal  out  1  sticky illegal-opcode flag.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH: o_mem_req=1, o_mem_fetch=1. On i_mem_ack, o_ir_wren=1 and go to DECODE.
- DECODE: always one cycle, no enables asserted; go to EXEC.
- EXEC, by opcode class:
  - R-type: op1=rs1, op2=rs2; go to WB.
  - I-ALU: op1=rs1, op2=imm; go to WB.
  - LUI: op2=imm, ALU op = pass-B; go to WB.
  - AUIPC: op1=PC, op2=imm, ALU op = add; go to WB.
  - JAL: op1=PC, op2=imm, add; go to WB.
  - JALR: op1=rs1, op2=imm, add; go to WB.
  - Load/store: op1=rs1, op2=imm, add; go to MEM.
  - Branch: op1=PC, op2=imm, add. o_pc_wren=1 and o_pc_sel=taken; retire; go to FETCH.
- Taken rule: beq = equal; bne = !equal; blt/bltu = less; bge/bgeu = !less. o_br_unsign=1 only for bltu, bgeu and sltu/sltiu.
- MEM: o_mem_req=1; o_mem_wren=1 for stores. ALU controls are held from EXEC.
  - Load: on ack, go to WB.
  - Store: on ack, o_pc_wren=1 (PC+4), retire, go to FETCH.
- WB: o_rd_wren=1, o_pc_wren=1, retire, go to FETCH.
  - JAL/JALR: o_pc_sel=1, wb_sel=11.
  - Load: wb_sel=10.
  - All others: pc_sel=0, wb_sel=00.
- ALU encoding: 0000 add, 0001 sub, 0010 sll, 0011 slt, 0100 sltu, 0101 xor, 0110 sra, 0111 srl, 1000 or, 1001 and, 1010 pass-B.
- Sub vs. add uses instr[30] only for R-type. sra vs. srl uses instr[30] for both R-type and I-type.
- Timeout: a wait counter increments each cycle in which o_mem_req=1 and i_mem_ack=0, and clears on ack or on state change. When the count equals MEM_TIMEOUT (nonzero), go to TRAP and set o_fault.
- TRAP: all enables and requests are 0. The FSM stays in TRAP until i_reset.
- o_instret increments on every o_retire and wraps modulo 2^CNT_W.

## Timing
- Outputs are combinational from the state register and i_instr. In branch EXEC they also depend on the comparator flags.
- Minimum latency, with acks arriving in the same cycle as the request:
  - Branch: 3 cycles.
  - ALU, jump and U-type: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- Each memory wait cycle adds 1 cycle.
- Handshake: o_mem_req stays high through the ack cycle inclusive. i_mem_ack while o_mem_req=0 is ignored.
- An ack in the same cycle the counter reaches MEM_TIMEOUT wins: there is no fault.
- Reset: state=FETCH, wait counter=0, o_instret=0, o_fault=0, o_illegal=0. All enables and o_mem_req are forced 0 while i_reset=1.
- Reset asserted mid-instruction aborts the instruction with no retire. FETCH restarts in the first cycle after reset is released.

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined: an unrecognised opcode in DECODE goes to TRAP and sets o_illegal.
- Not defined: an unrecognised opcode executes as a NOP. EXEC goes to WB with o_rd_wren forced 0, PC+4 and retire. o_illegal is tied to 0.

## Structure
- Shared package contents:
  - opcode constants for all RV32I classes;
  - ALU opcode constants;
  - the state enum type;
  - wb_sel encodings.
- Sub-module ctrl_decode: combinational decode of i_instr into an instruction-class one-hot, ALU opcode, br_unsign and a legal flag. The FSM lives in multicycle_ctrl.

## Test plan
- add x3,x1,x2 with ack in the same cycle → 4 cycles FETCH→DECODE→EXEC→WB. In WB: rd_wren=1, alu_opcode=0000, wb_sel=00. o_instret goes 0→1.
- lw with a 3-cycle data ack delay → load latency 8 cycles. In WB: wb_sel=10. mem_wren=0 throughout.
- bltu with i_br_less=1 → in EXEC: pc_wren=1, pc_sel=1, br_unsign=1. With i_br_less=0: pc_sel=0. Branch latency 3 cycles.
- Fetch ack withheld with MEM_TIMEOUT=15 → TRAP entered after 15 wait cycles and o_fault=1. Ack on the 15th cycle instead gives no fault.
- Opcode 7'b0000000 → with CTRL_ILLEGAL_TRAP_EN: TRAP and o_illegal=1. Without the macro: NOP retire, rd_wren=0.
- i_reset during MEM of sw → no mem_wren after the reset edge and instret unchanged. The first cycle after release is FETCH with o_mem_req=1.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: opcode
// constants, ALU operation encodings, FSM state type, write-back select
// encodings, the instruction-class one-hot and the ALU function helper.
package multicycle_ctrl_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_SLL   = 4'b0010;
    localparam logic [3:0] ALU_SLT   = 4'b0011;
    localparam logic [3:0] ALU_SLTU  = 4'b0100;
    localparam logic [3:0] ALU_XOR   = 4'b0101;
    localparam logic [3:0] ALU_SRA   = 4'b0110;
    localparam logic [3:0] ALU_SRL   = 4'b0111;
    localparam logic [3:0] ALU_OR    = 4'b1000;
    localparam logic [3:0] ALU_AND   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b10;
    localparam logic [1:0] WB_PC4  = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    // All-zero means the opcode is not recognised.
    typedef struct packed {
        logic r;
        logic i_alu;
        logic lui;
        logic auipc;
        logic jal;
        logic jalr;
        logic load;
        logic store;
        logic branch;
    } cls_t;

    // Subtract is only selectable on R-type (instr[30] is immediate data
    // on addi); shift-right arithmetic uses instr[30] on both forms.
    function automatic logic [3:0] alu_fn(input logic [2:0] funct3,
                                          input logic       alt,
                                          input logic       is_r);
        case (funct3)
            3'b000:  alu_fn = (alt && is_r) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_fn = ALU_SLL;
            3'b010:  alu_fn = ALU_SLT;
            3'b011:  alu_fn = ALU_SLTU;
            3'b100:  alu_fn = ALU_XOR;
            3'b101:  alu_fn = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_fn = ALU_OR;
            default: alu_fn = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode for multicycle_ctrl.
// Ports:
//   instr      in   32-bit instruction word
//   cls        out  instruction-class one-hot (all zero = unknown opcode)
//   alu_op     out  ALU operation for this instruction
//   br_unsign  out  unsigned compare (bltu, bgeu, sltu, sltiu)
//   legal      out  opcode recognised
module ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output cls_t        cls,
    output logic [3:0]  alu_op,
    output logic        br_unsign,
    output logic        legal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alt;
    logic       unused_instr;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign alt          = instr[30];
    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

    always_comb begin
        cls       = '0;
        alu_op    = ALU_ADD;
        br_unsign = 1'b0;
        case (opcode)
            OPC_R: begin
                cls.r     = 1'b1;
                alu_op    = alu_fn(funct3, alt, 1'b1);
                br_unsign = (funct3 == 3'b011);
            end
            OPC_I: begin
                cls.i_alu = 1'b1;
                alu_op    = alu_fn(funct3, alt, 1'b0);
                br_unsign = (funct3 == 3'b011);
            end
            OPC_LUI: begin
                cls.lui = 1'b1;
                alu_op  = ALU_PASSB;
            end
            OPC_AUIPC: cls.auipc = 1'b1;
            OPC_JAL:   cls.jal   = 1'b1;
            OPC_JALR:  cls.jalr  = 1'b1;
            OPC_LOAD:  cls.load  = 1'b1;
            OPC_STORE: cls.store = 1'b1;
            OPC_BRANCH: begin
                cls.branch = 1'b1;
                br_unsign  = (funct3[2:1] == 2'b11);
            end
            default: ;
        endcase
    end

    assign legal = |cls;

endmodule

// File: rtl/multicycle_ctrl.sv
// FSM control unit for the multi-cycle RV32I core. Sequences each
// instruction through fetch/decode/execute/memory/write-back, handshakes
// with a shared memory that may stall, resolves branches from comparator
// flags, flags memory timeouts and counts retired instructions.
// Ports:
//   i_clk, i_reset (sync, active high); i_instr; i_mem_ack;
//   i_br_equal, i_br_less (comparator flags);
//   o_mem_req/o_mem_wren/o_mem_fetch (memory), o_ir_wren, o_pc_wren,
//   o_pc_sel, o_br_unsign, o_op1_sel, o_op2_sel, o_alu_opcode,
//   o_rd_wren, o_wb_sel, o_retire, o_instret, o_fault, o_illegal.
// Build option: define CTRL_ILLEGAL_TRAP_EN to trap on unknown opcodes;
// otherwise they retire as NOPs and o_illegal stays 0.
//
// state    | meaning
// ---------+--------------------------------------------------------
// S_FETCH  | instruction fetch request, IR load on ack
// S_DECODE | one cycle for IR/register read to settle
// S_EXEC   | ALU operation; branches resolve and retire here
// S_MEM    | load/store data request; stores retire on ack
// S_WB     | register write and PC update, retire
// S_TRAP   | memory timeout or illegal opcode; left only by reset
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32,
    parameter int ALU_OP_W    = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [31:0]         i_instr,
    input  logic                i_mem_ack,
    input  logic                i_br_equal,
    input  logic                i_br_less,
    output logic                o_mem_req,
    output logic                o_mem_wren,
    output logic                o_mem_fetch,
    output logic                o_ir_wren,
    output logic                o_pc_wren,
    output logic                o_pc_sel,
    output logic                o_br_unsign,
    output logic                o_op1_sel,
    output logic                o_op2_sel,
    output logic [ALU_OP_W-1:0] o_alu_opcode,
    output logic                o_rd_wren,
    output logic [1:0]          o_wb_sel,
    output logic                o_retire,
    output logic [CNT_W-1:0]    o_instret,
    output logic                o_fault,
    output logic                o_illegal
);

    // Counter only has to hold MEM_TIMEOUT-1; it wraps harmlessly when
    // the timeout is disabled.
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t            state, state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  instret;
    logic              fault;

    cls_t       cls;
    logic [3:0] dec_alu_op;
    logic       legal;
    logic       taken;
    logic       timeout_hit;
    logic       alu_hold;
    logic       fault_set;
    logic       illegal_set;

    ctrl_decode u_decode (
        .instr     (i_instr),
        .cls       (cls),
        .alu_op    (dec_alu_op),
        .br_unsign (o_br_unsign),
        .legal     (legal)
    );

    always_comb begin
        case (i_instr[14:12])
            3'b000:         taken = i_br_equal;
            3'b001:         taken = !i_br_equal;
            3'b100, 3'b110: taken = i_br_less;
            3'b101, 3'b111: taken = !i_br_less;
            default:        taken = 1'b0;
        endcase
    end

    // Fires on the cycle that would be the MEM_TIMEOUT-th wait cycle, so an
    // ack arriving in that same cycle still wins.
    assign timeout_hit = (MEM_TIMEOUT != 0) && !i_mem_ack &&
                         (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_next   = state;
        o_mem_req    = 1'b0;
        o_mem_wren   = 1'b0;
        o_mem_fetch  = 1'b0;
        o_ir_wren    = 1'b0;
        o_pc_wren    = 1'b0;
        o_pc_sel     = 1'b0;
        o_op1_sel    = 1'b0;
        o_op2_sel    = 1'b0;
        o_alu_opcode = ALU_OP_W'(ALU_ADD);
        o_rd_wren    = 1'b0;
        o_wb_sel     = WB_ALU;
        o_retire     = 1'b0;
        alu_hold     = 1'b0;
        fault_set    = 1'b0;
        illegal_set  = 1'b0;

        case (state)
            S_FETCH: begin
                o_mem_req   = 1'b1;
                o_mem_fetch = 1'b1;
                if (i_mem_ack) begin
                    o_ir_wren  = 1'b1;
                    state_next = S_DECODE;
                end else if (timeout_hit) begin
                    fault_set  = 1'b1;
                    state_next = S_TRAP;
                end
            end
            S_DECODE: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                if (!legal) begin
                    illegal_set = 1'b1;
                    state_next  = S_TRAP;
                end else begin
                    state_next = S_EXEC;
                end
`else
                state_next = S_EXEC;
`endif
            end
            S_EXEC: begin
                alu_hold = 1'b1;
                if (cls.branch) begin
                    o_pc_wren  = 1'b1;
                    o_pc_sel   = taken;
                    o_retire   = 1'b1;
                    state_next = S_FETCH;
                end else if (cls.load || cls.store) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                alu_hold   = 1'b1;
                o_mem_req  = 1'b1;
                o_mem_wren = cls.store;
                if (i_mem_ack) begin
                    if (cls.store) begin
                        o_pc_wren  = 1'b1;
                        o_retire   = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (timeout_hit) begin
                    fault_set  = 1'b1;
                    state_next = S_TRAP;
                end
            end
            S_WB: begin
                alu_hold   = 1'b1;
                // Unknown opcodes reach here as NOPs with no class bit set.
                o_rd_wren  = cls.r | cls.i_alu | cls.lui | cls.auipc |
                             cls.jal | cls.jalr | cls.load;
                o_pc_wren  = 1'b1;
                o_pc_sel   = cls.jal | cls.jalr;
                o_retire   = 1'b1;
                if (cls.jal || cls.jalr)
                    o_wb_sel = WB_PC4;
                else if (cls.load)
                    o_wb_sel = WB_LOAD;
                state_next = S_FETCH;
            end
            S_TRAP: ;
            default: state_next = S_FETCH;
        endcase

        // ALU steering stays valid from EXEC until the instruction retires.
        if (alu_hold) begin
            o_op1_sel    = cls.auipc | cls.jal | cls.branch;
            o_op2_sel    = cls.i_alu | cls.lui | cls.auipc | cls.jal |
                           cls.jalr | cls.load | cls.store | cls.branch;
            o_alu_opcode = ALU_OP_W'(dec_alu_op);
        end

        if (i_reset) begin
            o_mem_req   = 1'b0;
            o_mem_wren  = 1'b0;
            o_mem_fetch = 1'b0;
            o_ir_wren   = 1'b0;
            o_pc_wren   = 1'b0;
            o_rd_wren   = 1'b0;
            o_retire    = 1'b0;
            fault_set   = 1'b0;
            illegal_set = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            instret  <= '0;
            fault    <= 1'b0;
        end else begin
            state <= state_next;
            if (o_mem_req && !i_mem_ack && (state_next == state))
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (o_retire)
                instret <= instret + 1'b1;
            if (fault_set)
                fault <= 1'b1;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            illegal <= 1'b0;
        else if (illegal_set)
            illegal <= 1'b1;
    end

    assign o_illegal = illegal;
`else
    logic unused_illegal;

    assign unused_illegal = legal | illegal_set;
    assign o_illegal      = 1'b0;
`endif

    assign o_instret = instret;
    assign o_fault   = fault;

endmodule
